soi_tx: RTL

SOI_TX -- requirements
Module: soi_tx

---
 rtl/soi_pkg.sv | 18 +
 rtl/soi_if.sv | 27 ++
 rtl/soi_fifo.sv | 52 +++++
 rtl/soi_tx.sv | 95 +++++++++
 4 files changed

// File: rtl/soi_pkg.sv
// Shared types for the signal-of-interest capture path.
// Default widths, record layout and FSM state encoding.
package soi_pkg;

  localparam int SOI_W_D = 8;
  localparam int TS_W_D  = 32;

  typedef struct packed {
    logic [TS_W_D-1:0]  ts;
    logic [SOI_W_D-1:0] val;
  } soi_rec_t;

  typedef enum logic {
    DISABLED = 1'b0,
    RUN      = 1'b1
  } soi_st_t;

endpackage

// File: rtl/soi_if.sv
// Record drain handshake between soi_tx and its consumer.
// The producer drives valid and head fields; the consumer drives ready.
interface soi_if import soi_pkg::*; #(
  parameter int SOI_W = SOI_W_D,
  parameter int TS_W  = TS_W_D
) ();

  logic             rec_valid;
  logic             rec_ready;
  logic [TS_W-1:0]  rec_ts;
  logic [SOI_W-1:0] rec_val;

  modport master (
    output rec_valid,
    output rec_ts,
    output rec_val,
    input  rec_ready
  );

  modport slave (
    input  rec_valid,
    input  rec_ts,
    input  rec_val,
    output rec_ready
  );

endinterface

// File: rtl/soi_fifo.sv
// Synchronous record FIFO; a push while full is taken if a pop
// happens in the same cycle. Occupancy tells full from empty.
module soi_fifo import soi_pkg::*; #(
  parameter int  DEPTH = 8,
  parameter type T     = soi_rec_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  T                       din,
  output T                       dout,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  wp;
  logic [AW-1:0]  rp;
  logic           empty;
  logic           wr;
  logic           rd;

  assign empty = (level == '0);
  assign full  = (level == (AW+1)'(DEPTH));
  assign rd    = pop && !empty;
  assign wr    = push && (!full || rd);
  assign dout  = empty ? '0 : mem[rp];

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      unique case ({wr, rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/soi_tx.sv
// Change-capture front end: timestamps every change of soi while
// enabled and queues {ts, val} records for a host drain.
module soi_tx import soi_pkg::*; #(
  parameter int SOI_W = SOI_W_D,
  parameter int TS_W  = TS_W_D,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [SOI_W-1:0]       soi,
  input  logic                   clr_ovf,
  soi_if.master                  rec,
  output logic                   ovf,
  output logic [15:0]            drop_cnt,
  output logic [$clog2(DEPTH):0] level
);

  typedef struct packed {
    logic [TS_W-1:0]  ts;
    logic [SOI_W-1:0] val;
  } rec_t;

  soi_st_t          state;
  soi_st_t          nstate;
  logic [TS_W-1:0]  ts;
  logic [SOI_W-1:0] prev;
  logic             push;
  logic             pop;
  logic             full;
  logic             drop;
  rec_t             din;
  rec_t             dout;

  assign din           = '{ts: ts, val: soi};
  assign rec.rec_valid = (level != '0);
  assign rec.rec_ts    = dout.ts;
  assign rec.rec_val   = dout.val;
  assign pop           = rec.rec_valid && rec.rec_ready;
  assign drop          = push && full && !pop;

  // Entering RUN always logs a baseline so the host knows the start value.
  always_comb begin
    nstate = state;
    push   = 1'b0;
    unique case (state)
      DISABLED: begin
        if (en) begin
          nstate = RUN;
          push   = 1'b1;
        end
      end
      RUN: begin
        if (!en) nstate = DISABLED;
        else     push   = (soi != prev);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= DISABLED;
      ts       <= '0;
      prev     <= '0;
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state <= nstate;
      ts    <= ts + 1'b1;
      if (en) prev <= soi;
      if (clr_ovf) begin
        ovf      <= drop;
        drop_cnt <= {15'd0, drop};
      end else if (drop) begin
        ovf <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  soi_fifo #(
    .DEPTH (DEPTH),
    .T     (rec_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .level (level)
  );

endmodule
